// File: rtl/wormhole_output_alloc_pkg.sv
// Shared types and helpers for the wormhole output allocator.
// Holds the allocator state encoding and a rotating first-set scan.
package noc_alloc_pkg;

  typedef enum logic {IDLE, LOCKED} alloc_state_t;

  // Upper bound on requesters handled by rr_first; callers zero-extend into this width.
  localparam int unsigned MAX_IN = 32;
  localparam int unsigned MAX_W  = 5;

  // One-hot of the first set bit of req[n-1:0], scanning ptr, ptr+1, ... modulo n.
  function automatic logic [MAX_IN-1:0] rr_first(input logic [MAX_IN-1:0] req,
                                                 input int unsigned       ptr,
                                                 input int unsigned       n);
    logic [MAX_IN-1:0] gnt;
    logic              found;
    int unsigned       idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_IN; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[MAX_W-1:0]]) begin
          gnt[idx[MAX_W-1:0]] = 1'b1;
          found               = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/wormhole_output_alloc_if.sv
// Handshake bundle between the input ports / downstream credits and one output allocator.
// master drives flits and credits; slave is the allocator.
interface wormhole_output_alloc_if #(
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned CREDITS = 4
);
  localparam int unsigned CNT_W = $clog2(CREDITS + 1);

  logic [NUM_IN-1:0] flit_valid;
  logic [NUM_IN-1:0] flit_head;
  logic [NUM_IN-1:0] flit_tail;
  logic              credit_in;
  logic [NUM_IN-1:0] sel;
  logic [NUM_IN-1:0] pop;
  logic              out_valid;
  logic              busy;
  logic [CNT_W-1:0]  credit_cnt;
  logic              credit_err;

  modport master (
    output flit_valid, flit_head, flit_tail, credit_in,
    input  sel, pop, out_valid, busy, credit_cnt, credit_err
  );

  modport slave (
    input  flit_valid, flit_head, flit_tail, credit_in,
    output sel, pop, out_valid, busy, credit_cnt, credit_err
  );

endinterface

// File: rtl/wormhole_output_alloc_rr_pick.sv
// Stateless round-robin pick: first requester at or after ptr, as one-hot and index.
module rr_pick_comb
  import noc_alloc_pkg::*;
#(
  parameter int unsigned  NUM_IN = 4,
  localparam int unsigned PTR_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] i_req,
  input  logic [PTR_W-1:0]  i_ptr,
  output logic [NUM_IN-1:0] o_gnt,
  output logic [PTR_W-1:0]  o_idx,
  output logic              o_any
);

  logic [MAX_IN-1:0] w_req_ext;
  logic [MAX_IN-1:0] w_gnt_ext;
  logic              w_unused_gnt;

  always_comb begin
    w_req_ext             = '0;
    w_req_ext[NUM_IN-1:0] = i_req;
    w_gnt_ext             = rr_first(w_req_ext, int'(i_ptr), NUM_IN);
    o_gnt                 = w_gnt_ext[NUM_IN-1:0];
    o_idx                 = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (o_gnt[i]) o_idx = PTR_W'(i);
    end
    o_any = |o_gnt;
  end

  assign w_unused_gnt = ^w_gnt_ext[MAX_IN-1:NUM_IN];

endmodule

// File: rtl/wormhole_output_alloc.sv
// Per-output wormhole allocator: round-robin on head flits, route locked until tail,
// credit-based flow control toward the downstream router.
module wormhole_output_alloc
  import noc_alloc_pkg::*;
#(
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned CREDITS = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  wormhole_output_alloc_if.slave  bus
);

  localparam int unsigned      PTR_W    = $clog2(NUM_IN);
  localparam int unsigned      CNT_W    = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CREDITS);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_IN - 1);

  alloc_state_t      r_state;
  alloc_state_t      w_state_d;
  logic [PTR_W-1:0]  r_owner;
  logic [PTR_W-1:0]  w_owner_d;
  logic [PTR_W-1:0]  r_rr_ptr;
  logic [PTR_W-1:0]  w_rr_ptr_d;
  logic [CNT_W-1:0]  r_credit_cnt;
  logic [CNT_W-1:0]  w_credit_cnt_d;
  logic              r_credit_err;
  logic              w_credit_err_d;

  logic [NUM_IN-1:0] w_elig;
  logic [NUM_IN-1:0] w_gnt;
  logic [PTR_W-1:0]  w_idx;
  logic              w_any;
  logic [NUM_IN-1:0] w_sel;
  logic              w_xfer;
  logic              w_has_credit;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_elig = bus.flit_valid & bus.flit_head;

  rr_pick_comb #(
    .NUM_IN (NUM_IN)
  ) u_pick (
    .i_req (w_elig),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_comb begin
    w_sel        = '0;
    w_state_d    = r_state;
    w_owner_d    = r_owner;
    w_rr_ptr_d   = r_rr_ptr;
    w_has_credit = (r_credit_cnt != '0);
    unique case (r_state)
      IDLE: begin
        if (w_has_credit && w_any) begin
          w_sel     = w_gnt;
          w_owner_d = w_idx;
          // Single-flit packet completes immediately; pointer moves past the winner.
          if (bus.flit_tail[w_idx]) w_rr_ptr_d = wrap_inc(w_idx);
          else                      w_state_d  = LOCKED;
        end
      end
      LOCKED: begin
        // Owner's head flit here is a protocol violation and is passed as body.
        if (w_has_credit && bus.flit_valid[r_owner]) begin
          w_sel[r_owner] = 1'b1;
          if (bus.flit_tail[r_owner]) begin
            w_state_d  = IDLE;
            w_rr_ptr_d = wrap_inc(r_owner);
          end
        end
      end
    endcase
  end

  always_comb begin
    w_xfer         = |w_sel;
    w_credit_cnt_d = r_credit_cnt;
    w_credit_err_d = r_credit_err | (bus.credit_in && (r_credit_cnt == CNT_MAX));
    if (w_xfer && !bus.credit_in) begin
      w_credit_cnt_d = r_credit_cnt - CNT_W'(1);
    end else if (!w_xfer && bus.credit_in && (r_credit_cnt != CNT_MAX)) begin
      w_credit_cnt_d = r_credit_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_rr_ptr     <= '0;
      r_credit_cnt <= CNT_MAX;
      r_credit_err <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_owner      <= w_owner_d;
      r_rr_ptr     <= w_rr_ptr_d;
      r_credit_cnt <= w_credit_cnt_d;
      r_credit_err <= w_credit_err_d;
    end
  end

  assign bus.sel        = w_sel;
  assign bus.pop        = w_sel;
  assign bus.out_valid  = w_xfer;
  assign bus.busy       = (r_state == LOCKED);
  assign bus.credit_cnt = r_credit_cnt;
  assign bus.credit_err = r_credit_err;

endmodule

// File: tb/tb_wormhole_output_alloc.sv
// Scoreboard bench for wormhole_output_alloc: each driven cycle queues its expected
// outputs, and the negedge monitor pops and compares them.
module tb_wormhole_output_alloc;

  logic clk;
  logic rst_n;

  wormhole_output_alloc_if #(.NUM_IN(4), .CREDITS(4)) bus ();

  wormhole_output_alloc #(
    .NUM_IN  (4),
    .CREDITS (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] sel;
    logic       busy;
    logic [2:0] cnt;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_step   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_eq($sformatf("s%0d_sel", n_step), 32'(bus.sel), 32'(e.sel));
      check_eq($sformatf("s%0d_pop", n_step), 32'(bus.pop), 32'(e.sel));
      check_eq($sformatf("s%0d_out_valid", n_step), 32'(bus.out_valid), 32'(|e.sel));
      check_eq($sformatf("s%0d_busy", n_step), 32'(bus.busy), 32'(e.busy));
      check_eq($sformatf("s%0d_credit_cnt", n_step), 32'(bus.credit_cnt), 32'(e.cnt));
      check_eq($sformatf("s%0d_credit_err", n_step), 32'(bus.credit_err), 32'(e.err));
      n_step++;
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic step(input logic [3:0] v, input logic [3:0] h, input logic [3:0] t,
                      input logic cin, input logic [3:0] esel, input logic ebusy,
                      input logic [2:0] ecnt, input logic eerr);
    exp_t e;
    bus.flit_valid = v;
    bus.flit_head  = h;
    bus.flit_tail  = t;
    bus.credit_in  = cin;
    e.sel  = esel;
    e.busy = ebusy;
    e.cnt  = ecnt;
    e.err  = eerr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rot;
    rst_n          = 1'b0;
    bus.flit_valid = '0;
    bus.flit_head  = '0;
    bus.flit_tail  = '0;
    bus.credit_in  = 1'b0;
    @(posedge clk);
    #1;

    // Reset values
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd4, 1'b0);
    rst_n = 1'b1;

    // Single-flit packets on all inputs: rotation 0,1,2,3,0,1; credits settle at 3
    step(4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b0, 3'd4, 1'b0);
    for (int i = 1; i < 6; i++) begin
      rot = 4'b0001 << (i % 4);
      step(4'b1111, 4'b1111, 4'b1111, 1'b1, rot, 1'b0, 3'd3, 1'b0);
    end
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'd3, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd4, 1'b0);

    // Input 1 sends H,B,T while input 2 waits with a head; then rr_ptr=2 beats input 0
    step(4'b0010, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0, 3'd4, 1'b0);
    step(4'b0110, 4'b0100, 4'b0000, 1'b0, 4'b0010, 1'b1, 3'd3, 1'b0);
    step(4'b0110, 4'b0100, 4'b0010, 1'b0, 4'b0010, 1'b1, 3'd2, 1'b0);
    step(4'b0101, 4'b0101, 4'b0101, 1'b0, 4'b0100, 1'b0, 3'd1, 1'b0);
    // Zero credits: pending head is not granted
    step(4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 3'd0, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'd1, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'd2, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'd3, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd4, 1'b0);

    // Input 0 streams a 6-flit packet with credits starved after 4 flits
    step(4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 3'd4, 1'b0);
    step(4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b1, 3'd3, 1'b0);
    step(4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b1, 3'd2, 1'b0);
    step(4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b1, 3'd1, 1'b0);
    step(4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 3'd0, 1'b0);
    step(4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 3'd0, 1'b0);
    step(4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 3'd0, 1'b0);
    step(4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b1, 3'd1, 1'b0);
    step(4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 3'd0, 1'b0);
    step(4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 3'd0, 1'b0);
    // Tail transfer with a returning credit: count unchanged
    step(4'b0001, 4'b0000, 4'b0001, 1'b1, 4'b0001, 1'b1, 3'd1, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'd1, 1'b0);

    // Transfer plus credit at count 2, then overflow credit sets the sticky error
    step(4'b0010, 4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0, 3'd2, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'd2, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'd3, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'd4, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd4, 1'b1);

    // Owner 3 bubbles for two cycles; input 0's head waits until 3's tail
    step(4'b1000, 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0, 3'd4, 1'b1);
    step(4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b1, 3'd3, 1'b1);
    step(4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b1, 3'd3, 1'b1);
    step(4'b1001, 4'b0001, 4'b1000, 1'b0, 4'b1000, 1'b1, 3'd3, 1'b1);
    step(4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 3'd2, 1'b1);

    // Second flit of input 0's packet, then asynchronous reset mid-packet
    step(4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b1, 3'd1, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_sel", 32'(bus.sel), 32'h0);
    check_eq("async_rst_busy", 32'(bus.busy), 32'h0);
    check_eq("async_rst_credit_cnt", 32'(bus.credit_cnt), 32'h4);
    check_eq("async_rst_credit_err", 32'(bus.credit_err), 32'h0);
    step(4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd4, 1'b0);
    rst_n = 1'b1;
    // rr_ptr back at 0: input 0 first, then input 2
    step(4'b0101, 4'b0101, 4'b0101, 1'b0, 4'b0001, 1'b0, 3'd4, 1'b0);
    step(4'b0101, 4'b0101, 4'b0101, 1'b0, 4'b0100, 1'b0, 3'd3, 1'b0);

    bus.flit_valid = '0;
    bus.credit_in  = 1'b0;
    @(posedge clk);
    #1;
    check_eq("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
